// File: rtl/dma_bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// dma_bus_arbiter_pkg
// Shared constants for the DMA bus arbiter: default sizing, FSM state
// encodings and the channel-id width helper.
// No ports (package).
// ----------------------------------------------------------------------------
package dma_bus_arbiter_pkg;

  localparam int NUM_CH_DEF    = 4;
  localparam int WORD_SIZE_DEF = 16;
  localparam int MAX_GRANT_DEF = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;
  localparam logic [1:0] ST_REL   = 2'd3;

  // Channel-id width; a single channel still needs one id bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// dma_bus_arbiter_if
// Request/grant bundle between the DMA channels, the D-cache idle flag and
// the arbiter.
//   br          per-channel bus request (level)
//   ch_addr     per-channel target address, channel i at [i*WORD_SIZE +: WORD_SIZE]
//   dmem_idle   D-cache has nothing in flight
//   bg          one-hot bus grant
//   cpu_hold    CPU must not start a new data access
//   begin_irq / end_irq / irq_ch   grant start/stop pulses with channel id
//   timeout_err sticky forced-revoke flag
// Modports: master = arbiter (owns the grant), slave = channels/CPU side.
// ----------------------------------------------------------------------------
interface dma_bus_arbiter_if
  import dma_bus_arbiter_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int CH_W      = ch_w(NUM_CH)
);
  logic [NUM_CH-1:0]           br;
  logic [NUM_CH*WORD_SIZE-1:0] ch_addr;
  logic                        dmem_idle;
  logic [NUM_CH-1:0]           bg;
  logic                        cpu_hold;
  logic                        begin_irq;
  logic                        end_irq;
  logic [CH_W-1:0]             irq_ch;
  logic                        timeout_err;

  modport master (
    input  br, ch_addr, dmem_idle,
    output bg, cpu_hold, begin_irq, end_irq, irq_ch, timeout_err
  );

  modport slave (
    output br, ch_addr, dmem_idle,
    input  bg, cpu_hold, begin_irq, end_irq, irq_ch, timeout_err
  );
endinterface

// File: rtl/dma_bus_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// dma_bus_arbiter_rr_picker
// Combinational winner selection.
//   req     in   NUM_CH  request vector
//   rr_ptr  in   CH_W    first channel considered in round-robin mode
//   valid   out  1       any request present
//   sel     out  CH_W    winning channel
// The request vector is duplicated so that a scan starting at rr_ptr wraps
// past the top channel without modulo logic in the encoder; fixed mode is the
// same scan with the start forced to 0.
// ----------------------------------------------------------------------------
module dma_bus_arbiter_rr_picker
  import dma_bus_arbiter_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int CH_W    = ch_w(NUM_CH),
  parameter bit RR_MODE = 1'b1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic              valid,
  output logic [CH_W-1:0]   sel
);

  logic [2*NUM_CH-1:0] dbl;
  logic [CH_W-1:0]     base;
  logic [CH_W:0]       hit;

  always_comb begin
    base  = RR_MODE ? rr_ptr : '0;
    dbl   = {req, req};
    valid = |req;
    hit   = '0;
    // Descending scan so the lowest index inside the window wins.
    for (int i = 2*NUM_CH-1; i >= 0; i--) begin
      if (dbl[i] && (i >= int'(base)) && (i < int'(base) + NUM_CH)) begin
        hit = (CH_W+1)'(i);
      end
    end
    sel = CH_W'((hit >= (CH_W+1)'(NUM_CH)) ? hit - (CH_W+1)'(NUM_CH) : hit);
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// ----------------------------------------------------------------------------
// dma_bus_arbiter
// Owns the memory-port-2 bus grant between the CPU D-cache side and NUM_CH
// DMA channels. A channel is granted only once the D-cache reports idle; the
// CPU is held from arbitration until the grant is released.
//   clk       in   clock, all state on posedge
//   reset     in   asynchronous, active-high
//   bus       dma_bus_arbiter_if.master (requests, idle flag, grants, irqs)
//   dma_addr  out  granted channel's address, high-Z when nothing is granted
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no grant, CPU free; arbitrate on any request
// ST_WAIT  | winner latched, CPU held, waiting for the D-cache to drain
// ST_GRANT | bg[sel] high, grant_cnt running toward the revoke limit
// ST_REL   | one-cycle release: bg low, end_irq, CPU freed, pointer moved
// ----------------------------------------------------------------------------
module dma_bus_arbiter
  import dma_bus_arbiter_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int CH_W      = ch_w(NUM_CH),
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter bit RR_MODE   = 1'b1,
  parameter int MAX_GRANT = MAX_GRANT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  dma_bus_arbiter_if.master     bus,
  output wire  [WORD_SIZE-1:0]  dma_addr
);

  localparam int CNT_W = (MAX_GRANT > 0) ? $clog2(MAX_GRANT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_GRANT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_GRANT > 0) ? MAX_GRANT - 1 : 0);
  localparam bit LIMIT_EN = (MAX_GRANT != 0);

  logic [1:0]        state;
  logic [CH_W-1:0]   sel;
  logic [CH_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  grant_cnt;
  logic [NUM_CH-1:0] bg_q;
  logic              cpu_hold_q;
  logic              begin_irq_q;
  logic              end_irq_q;
  logic [CH_W-1:0]   irq_ch_q;
  logic              timeout_err_q;

  logic              pick_valid;
  logic [CH_W-1:0]   pick_sel;
  logic              req_sel;
  logic              limit_hit;
  logic              rel_now;
  logic [CH_W-1:0]   sel_next;

  dma_bus_arbiter_rr_picker #(
    .NUM_CH  (NUM_CH),
    .CH_W    (CH_W),
    .RR_MODE (RR_MODE)
  ) u_picker (
    .req    (bus.br),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .sel    (pick_sel)
  );

  assign req_sel   = bus.br[sel];
  assign limit_hit = LIMIT_EN && (grant_cnt == CNT_LAST);
  // A drop on the same cycle as the limit is a normal release, so the
  // timeout only counts while the request is still up.
  assign rel_now   = (state == ST_GRANT) && (!req_sel || limit_hit);
  assign sel_next  = (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      sel           <= '0;
      rr_ptr        <= '0;
      grant_cnt     <= '0;
      bg_q          <= '0;
      cpu_hold_q    <= 1'b0;
      begin_irq_q   <= 1'b0;
      end_irq_q     <= 1'b0;
      irq_ch_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      begin_irq_q <= 1'b0;
      end_irq_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            sel        <= pick_sel;
            cpu_hold_q <= 1'b1;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!req_sel) begin
            cpu_hold_q <= 1'b0;
            state      <= ST_IDLE;
          end else if (bus.dmem_idle) begin
            bg_q        <= NUM_CH'(1) << sel;
            begin_irq_q <= 1'b1;
            irq_ch_q    <= sel;
            grant_cnt   <= '0;
            state       <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (rel_now) begin
            bg_q       <= '0;
            end_irq_q  <= 1'b1;
            irq_ch_q   <= sel;
            rr_ptr     <= sel_next;
            cpu_hold_q <= 1'b0;
            grant_cnt  <= '0;
            state      <= ST_REL;
            if (req_sel) begin
              timeout_err_q <= 1'b1;
            end
          end else if (grant_cnt != CNT_SAT) begin
            grant_cnt <= grant_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.bg          = bg_q;
  assign bus.cpu_hold    = cpu_hold_q;
  assign bus.begin_irq   = begin_irq_q;
  assign bus.end_irq     = end_irq_q;
  assign bus.irq_ch      = irq_ch_q;
  assign bus.timeout_err = timeout_err_q;

  // Driven from the registered grant, so an async reset floats it at once.
  assign dma_addr = (bg_q != '0) ? bus.ch_addr[sel*WORD_SIZE +: WORD_SIZE] : 'z;

endmodule
